// File: rtl/ps2_rx_ctrl.sv
// rtl/ps2_rx_ctrl.sv - PS/2 receive controller: synchroniser, frame FSM with watchdog, scancode FIFO, register slave
module ps2_rx_ctrl #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       s_cs_n,
  input  logic [1:0] s_address,
  input  logic       s_read,
  output logic [7:0] s_readdata,
  input  logic       s_write,
  input  logic [7:0] s_writedata,
  output logic       irq,
  input  logic       kc,
  input  logic       kd
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int WD_W  = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} state_t;

  // Synchronisers reset high so the line looks idle and no fall is seen after reset
  logic kc_s1, kc_s2, kc_prev, kd_s1, kd_s2;
  logic fall;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      kc_s1   <= 1'b1;
      kc_s2   <= 1'b1;
      kc_prev <= 1'b1;
      kd_s1   <= 1'b1;
      kd_s2   <= 1'b1;
    end else begin
      kc_s1   <= kc;
      kc_s2   <= kc_s1;
      kc_prev <= kc_s2;
      kd_s1   <= kd;
      kd_s2   <= kd_s1;
    end
  end

  assign fall = kc_prev & ~kc_s2;

  state_t            state, state_n;
  logic [7:0]        shift_reg;
  logic [2:0]        bitcnt;
  logic              parity_bit;
  logic [WD_W-1:0]   wd_cnt;
  logic              shift_en, bit_clr, par_cap, wd_clr, wd_inc;
  logic              frame_good, set_perr, set_ferr;

  logic              enable, irq_en;
  logic              ovf_flag, perr_flag, ferr_flag;
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [7:0]        mem [FIFO_DEPTH];
  logic              not_empty, full, pop, push, ovf_set;
  logic              bus_sel, wr_status, wr_ctrl;
  logic              unused_wdata;

  always_comb begin
    state_n    = state;
    shift_en   = 1'b0;
    bit_clr    = 1'b0;
    par_cap    = 1'b0;
    wd_clr     = 1'b0;
    wd_inc     = 1'b0;
    frame_good = 1'b0;
    set_perr   = 1'b0;
    set_ferr   = 1'b0;
    if (!enable) begin
      state_n = ST_IDLE;
      wd_clr  = 1'b1;
    end else if (state == ST_IDLE) begin
      wd_clr = 1'b1;
      if (fall) begin
        if (!kd_s2) begin
          state_n = ST_DATA;
          bit_clr = 1'b1;
        end else begin
          set_ferr = 1'b1;
        end
      end
    end else if (!fall) begin
      if (wd_cnt == WD_MAX) begin
        state_n  = ST_IDLE;
        set_ferr = 1'b1;
        wd_clr   = 1'b1;
      end else begin
        wd_inc = 1'b1;
      end
    end else begin
      wd_clr = 1'b1;
      case (state)
        ST_DATA: begin
          shift_en = 1'b1;
          if (bitcnt == 3'd7) state_n = ST_PARITY;
        end
        ST_PARITY: begin
          par_cap = 1'b1;
          state_n = ST_STOP;
        end
        default: begin
          state_n = ST_IDLE;
          if (!kd_s2)                        set_ferr   = 1'b1;
          else if (^{shift_reg, parity_bit}) frame_good = 1'b1;
          else                               set_perr   = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      shift_reg  <= 8'h00;
      bitcnt     <= 3'd0;
      parity_bit <= 1'b0;
      wd_cnt     <= '0;
    end else begin
      state <= state_n;
      if (bit_clr)       bitcnt <= 3'd0;
      else if (shift_en) bitcnt <= bitcnt + 3'd1;
      if (shift_en) shift_reg  <= {kd_s2, shift_reg[7:1]};
      if (par_cap)  parity_bit <= kd_s2;
      if (wd_clr)      wd_cnt <= '0;
      else if (wd_inc) wd_cnt <= wd_cnt + 1'b1;
    end
  end

  assign bus_sel   = ~s_cs_n;
  assign wr_status = bus_sel & s_write & (s_address == 2'd1);
  assign wr_ctrl   = bus_sel & s_write & (s_address == 2'd2);
  assign not_empty = (count != '0);
  assign full      = (count == CNT_FULL);
  assign pop       = bus_sel & s_read & (s_address == 2'd0) & not_empty;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the byte
  assign push      = frame_good & (~full | pop);
  assign ovf_set   = frame_good & full & ~pop;
  assign unused_wdata = ^s_writedata[7:5];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shift_reg;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      enable    <= 1'b1;
      irq_en    <= 1'b1;
      ovf_flag  <= 1'b0;
      perr_flag <= 1'b0;
      ferr_flag <= 1'b0;
      irq       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
      if (wr_ctrl) begin
        enable <= s_writedata[0];
        irq_en <= s_writedata[1];
      end
      ovf_flag  <= (ovf_flag  & ~(wr_status & s_writedata[2])) | ovf_set;
      perr_flag <= (perr_flag & ~(wr_status & s_writedata[3])) | set_perr;
      ferr_flag <= (ferr_flag & ~(wr_status & s_writedata[4])) | set_ferr;
      irq <= irq_en & (not_empty | ovf_flag | perr_flag | ferr_flag);
    end
  end

  always_comb begin
    s_readdata = 8'h00;
    case (s_address)
      2'd0:    s_readdata = not_empty ? mem[rd_ptr] : 8'h00;
      2'd1:    s_readdata = {3'b000, ferr_flag, perr_flag, ovf_flag, full, not_empty};
      2'd2:    s_readdata = {6'b000000, irq_en, enable};
      default: s_readdata = 8'(count);
    endcase
  end

endmodule

// File: tb/tb_ps2_rx_ctrl.sv
// tb/tb_ps2_rx_ctrl.sv - scoreboard bench for ps2_rx_ctrl
module tb_ps2_rx_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 500;
  localparam int HALF    = 20;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       s_cs_n = 1'b1;
  logic [1:0] s_address = 2'd0;
  logic       s_read = 1'b0;
  logic [7:0] s_readdata;
  logic       s_write = 1'b0;
  logic [7:0] s_writedata = 8'h00;
  logic       irq;
  logic       kc = 1'b1;
  logic       kd = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] sb[$];

  ps2_rx_ctrl #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n), .s_cs_n(s_cs_n), .s_address(s_address),
    .s_read(s_read), .s_readdata(s_readdata), .s_write(s_write),
    .s_writedata(s_writedata), .irq(irq), .kc(kc), .kd(kd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [7:0] d);
    @(negedge clk);
    s_cs_n = 1'b0; s_read = 1'b1; s_address = addr;
    #1 d = s_readdata;
    @(posedge clk);
    #1 s_cs_n = 1'b1; s_read = 1'b0;
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [7:0] d);
    @(negedge clk);
    s_cs_n = 1'b0; s_write = 1'b1; s_address = addr; s_writedata = d;
    @(posedge clk);
    #1 s_cs_n = 1'b1; s_write = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] addr, input logic [7:0] exp);
    logic [7:0] d;
    bus_read(addr, d);
    check(tag, d, exp);
  endtask

  // Drives nbits of a frame; optionally issues a DATA read on the exact edge the stop bit is pushed
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input int nbits,
                            input bit rd_on_stop, output logic [7:0] rd);
    logic [10:0] bits;
    bits = {1'b1, (~^d) ^ bad_par, d, 1'b0};
    rd = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      kd = bits[i];
      repeat (HALF) @(negedge clk);
      kc = 1'b0;
      if (i == 10 && rd_on_stop) begin
        @(posedge clk);
        @(posedge clk);
        bus_read(2'd0, rd);
        repeat (HALF - 2) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      kc = 1'b1;
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic send_good(input logic [7:0] d);
    logic [7:0] rd;
    send_frame(d, 1'b0, 11, 1'b0, rd);
    if (sb.size() < DEPTH) sb.push_back(d);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] d;
    logic [7:0] exp;
    exp = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    bus_read(2'd0, d);
    check(tag, d, exp);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [7:0] rd;
    logic [7:0] old_head;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    check("reset_irq", irq, 1'b0);
    read_check("reset_data",   2'd0, 8'h00);
    read_check("reset_status", 2'd1, 8'h00);
    read_check("reset_ctrl",   2'd2, 8'h03);
    read_check("reset_count",  2'd3, 8'h00);

    send_good(8'h1C);
    read_check("1c_count",  2'd3, 8'h01);
    read_check("1c_status", 2'd1, 8'h01);
    check("1c_irq", irq, 1'b1);
    pop_check("1c_data");
    read_check("1c_count_after", 2'd3, 8'h00);
    check("1c_irq_after", irq, 1'b0);

    send_frame(8'hF0, 1'b1, 11, 1'b0, rd);
    read_check("par_count",  2'd3, 8'h00);
    read_check("par_status", 2'd1, 8'h08);
    check("par_irq", irq, 1'b1);
    bus_write(2'd1, 8'h08);
    @(posedge clk); #1;
    check("par_irq_clr", irq, 1'b0);
    read_check("par_status_clr", 2'd1, 8'h00);

    for (int i = 1; i <= 9; i++) send_good(8'(i));
    read_check("ovf_count",  2'd3, 8'h08);
    read_check("ovf_status", 2'd1, 8'h07);
    for (int i = 0; i < 9; i++) pop_check($sformatf("ovf_read%0d", i));
    bus_write(2'd1, 8'h04);
    read_check("ovf_status_clr", 2'd1, 8'h00);

    send_frame(8'h5A, 1'b0, 5, 1'b0, rd);
    repeat (TIMEOUT + 100) @(negedge clk);
    read_check("to_status", 2'd1, 8'h10);
    read_check("to_count",  2'd3, 8'h00);
    bus_write(2'd1, 8'h10);
    send_good(8'h2A);
    read_check("to_status_next", 2'd1, 8'h01);
    pop_check("to_data_2a");

    send_good(8'h11);
    send_good(8'h22);
    send_good(8'h33);
    read_check("sim_count_pre", 2'd3, 8'h03);
    old_head = sb.pop_front();
    send_frame(8'h44, 1'b0, 11, 1'b1, rd);
    sb.push_back(8'h44);
    check("sim_read_head", rd, old_head);
    read_check("sim_count_post", 2'd3, 8'h03);
    for (int i = 0; i < 3; i++) pop_check($sformatf("sim_drain%0d", i));
    read_check("sim_status", 2'd1, 8'h00);

    bus_write(2'd2, 8'h02);
    send_frame(8'h55, 1'b0, 11, 1'b0, rd);
    read_check("dis_count",  2'd3, 8'h00);
    read_check("dis_status", 2'd1, 8'h00);
    check("dis_irq", irq, 1'b0);
    bus_write(2'd2, 8'h03);
    send_good(8'h66);
    bus_write(2'd2, 8'h01);
    @(posedge clk); #1;
    check("noirq_irq", irq, 1'b0);
    read_check("noirq_status", 2'd1, 8'h01);
    read_check("noirq_ctrl",   2'd2, 8'h01);
    pop_check("noirq_data");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
